// File: rtl/fb_write_arbiter_pkg.sv
// rtl/fb_write_arbiter_pkg.sv - shared types and defaults for the framebuffer write arbiter
package fb_write_arbiter_pkg;

  localparam int         COORD_W         = 11;
  localparam logic [7:0] DEF_CLEAR_COLOR = 8'hFF;
  localparam int         DEF_H_PIX       = 320;
  localparam int         DEF_V_PIX       = 240;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/clear_sweep_counter.sv
// rtl/clear_sweep_counter.sv - column/row scan counter for the clear sweep, column fastest
module clear_sweep_counter
  import fb_write_arbiter_pkg::*;
#(
  parameter int H_PIX = DEF_H_PIX,
  parameter int V_PIX = DEF_V_PIX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               advance_i,
  output logic [COORD_W-1:0] col_o,
  output logic [COORD_W-1:0] row_o,
  output logic               last_o
);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic               col_wrap;

  assign col_wrap = (col_q == COORD_W'(H_PIX - 1));
  assign last_o   = col_wrap && (row_q == COORD_W'(V_PIX - 1));
  assign col_o    = col_q;
  assign row_o    = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (advance_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin pixel write arbiter with framebuffer clear sweep
// Optional FB_AUTOCLEAR_EN: run one full clear sweep right after reset release.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter logic [7:0] CLEAR_COLOR = DEF_CLEAR_COLOR,
  parameter int         H_PIX       = DEF_H_PIX,
  parameter int         V_PIX       = DEF_V_PIX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_req,
  output logic               clear_busy,
  input  logic               req0_valid,
  input  logic [7:0]         req0_data,
  input  logic [COORD_W-1:0] req0_x,
  input  logic [COORD_W-1:0] req0_y,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [7:0]         req1_data,
  input  logic [COORD_W-1:0] req1_x,
  input  logic [COORD_W-1:0] req1_y,
  output logic               req1_ready,
  output logic               wr_en,
  output logic [7:0]         wr_data,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y
);

`ifdef FB_AUTOCLEAR_EN
  localparam logic AUTOCLEAR = 1'b1;
`else
  localparam logic AUTOCLEAR = 1'b0;
`endif

  state_e             state_q, state_d;
  logic               rr_q, rr_d;       // requester preferred on a tie
  logic               auto_q, auto_d;
  logic               wr_en_q, wr_en_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [COORD_W-1:0] wr_x_q, wr_x_d;
  logic [COORD_W-1:0] wr_y_q, wr_y_d;
  logic               grant0, grant1;
  logic [COORD_W-1:0] col, row;
  logic               last_pix;

  clear_sweep_counter #(
    .H_PIX (H_PIX),
    .V_PIX (V_PIX)
  ) u_sweep (
    .clock     (clock),
    .reset     (reset),
    .advance_i (state_q == CLEAR),
    .col_o     (col),
    .row_o     (row),
    .last_o    (last_pix)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    auto_d    = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    case (state_q)
      IDLE: begin
        if (clear_req || auto_q) begin
          state_d = CLEAR;
        end else if (req0_valid && (!req1_valid || !rr_q)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0) begin
          rr_d      = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = req0_data;
          wr_x_d    = req0_x;
          wr_y_d    = req0_y;
        end else if (grant1) begin
          rr_d      = 1'b0;
          wr_en_d   = 1'b1;
          wr_data_d = req1_data;
          wr_x_d    = req1_x;
          wr_y_d    = req1_y;
        end
      end
      CLEAR: begin
        // Sweep runs at half resolution onto the 640x480 coordinate grid.
        wr_en_d   = 1'b1;
        wr_data_d = CLEAR_COLOR;
        wr_x_d    = col << 1;
        wr_y_d    = row << 1;
        if (last_pix) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      auto_q    <= AUTOCLEAR;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      auto_q    <= auto_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
    end
  end

  assign req0_ready = grant0 && reset;
  assign req1_ready = grant1 && reset;
  assign clear_busy = (state_q == CLEAR);
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - self-checking bench for fb_write_arbiter
module tb_fb_write_arbiter;

  localparam int H = 320;
  localparam int V = 240;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic [10:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        req0_ready, req1_ready;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [10:0] wr_x, wr_y;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Requester-side view used by the reference model
  logic        v  [2];
  logic [7:0]  pd [2];
  logic [10:0] px [2];
  logic [10:0] py [2];
  int          last_g;
  logic        exp_en;
  logic [29:0] exp_w;

  always #5 clock = ~clock;

  fb_write_arbiter #(
    .CLEAR_COLOR (8'hFF),
    .H_PIX       (H),
    .V_PIX       (V)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_x       (wr_x),
    .wr_y       (wr_y)
  );

  task automatic drive_reqs();
    req0_valid = v[0]; req0_data = pd[0]; req0_x = px[0]; req0_y = py[0];
    req1_valid = v[1]; req1_data = pd[1]; req1_x = px[1]; req1_y = py[1];
  endtask

  task automatic set_req(input int n, input logic [7:0] d, input int x, input int y);
    v[n] = 1'b1; pd[n] = d; px[n] = 11'(x); py[n] = 11'(y);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; clear_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; pd[n] = '0; px[n] = '0; py[n] = '0;
    end
    drive_reqs();
    @(negedge clock);
    reset = 1'b1;
    last_g = 1;
    exp_en = 1'b0;
`ifdef FB_AUTOCLEAR_EN
    begin
      bit started = 0;
      bit done = 0;
      for (int i = 0; i < 80000 && !done; i++) begin
        @(negedge clock);
        if (clear_busy) started = 1;
        else if (started && !wr_en) done = 1;
      end
      cmp_cnt++;
      if (!done) begin
        err_cnt++;
        $display("FAIL autoclear_wait: got started=%0d done=%0d expected done=1", started, done);
      end
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    set_req(0, 8'hAA, 5, 7);
    drive_reqs();
    @(negedge clock);
    cmp_cnt++;
    if ({wr_en, wr_data} !== {1'b1, 8'hAA}) begin
      err_cnt++;
      $display("FAIL pre_reset_write: got en=%b data=%h expected en=1 data=aa", wr_en, wr_data);
    end
    reset = 1'b0; v[0] = 1'b0; drive_reqs();
    @(negedge clock);
    cmp_cnt++;
    if ({wr_en, wr_data, wr_x, wr_y, clear_busy} !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got en=%b d=%h x=%0d y=%0d busy=%b expected all 0",
               wr_en, wr_data, wr_x, wr_y, clear_busy);
    end
    reset = 1'b1;
    last_g = 1;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c >= 1 && c <= 3) begin
        cmp_cnt++;
        if ({wr_en, wr_data, wr_x, wr_y} !== {1'b1, 8'h3C, 11'd100, 11'd50}) begin
          err_cnt++;
          $display("FAIL single_write c=%0d: got en=%b d=%h x=%0d y=%0d expected 1 3c 100 50",
                   c, wr_en, wr_data, wr_x, wr_y);
        end
      end
      if (c == 4) begin
        cmp_cnt++;
        if (wr_en !== 1'b0) begin
          err_cnt++;
          $display("FAIL single_idle: got wr_en=%b expected 0", wr_en);
        end
      end
      if (c < 3) set_req(0, 8'h3C, 100, 50);
      else v[0] = 1'b0;
      drive_reqs();
      #1;
      if (c < 3) begin
        cmp_cnt++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
          err_cnt++;
          $display("FAIL single_ready c=%0d: got %b%b expected 01", c, req1_ready, req0_ready);
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] d_exp;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c >= 1) begin
        d_exp = ((c - 1) % 2 == 0) ? 8'h11 : 8'h22;
        cmp_cnt++;
        if ({wr_en, wr_data} !== {1'b1, d_exp}) begin
          err_cnt++;
          $display("FAIL alt_write c=%0d: got en=%b d=%h expected 1 %h", c, wr_en, wr_data, d_exp);
        end
      end
      if (c < 4) begin
        set_req(0, 8'h11, 10, 20);
        set_req(1, 8'h22, 30, 40);
      end else begin
        v[0] = 1'b0; v[1] = 1'b0;
      end
      drive_reqs();
      #1;
      if (c < 4) begin
        cmp_cnt++;
        if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
          err_cnt++;
          $display("FAIL alt_grant c=%0d: got %b%b expected grant %0d", c, req1_ready, req0_ready, c % 2);
        end
      end
    end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      cmp_cnt++;
      if (wr_en !== exp_en || (exp_en && {wr_data, wr_x, wr_y} !== exp_w)) begin
        err_cnt++;
        $display("FAIL rand_write c=%0d: got en=%b w=%h expected en=%b w=%h",
                 c, wr_en, {wr_data, wr_x, wr_y}, exp_en, exp_w);
      end
      for (int n = 0; n < 2; n++)
        if (!v[n] && $urandom_range(0, 99) < 55)
          set_req(n, 8'($urandom), $urandom_range(0, 639), $urandom_range(0, 479));
      drive_reqs();
      #1;
      g = -1;
      if (v[0] && v[1]) g = (last_g == 0) ? 1 : 0;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
      cmp_cnt++;
      if ({req1_ready, req0_ready} !== {g == 1, g == 0}) begin
        err_cnt++;
        $display("FAIL rand_grant c=%0d: got %b%b expected grant %0d", c, req1_ready, req0_ready, g);
      end
      exp_en = (g >= 0);
      if (g >= 0) begin
        exp_w  = {pd[g], px[g], py[g]};
        last_g = g;
        v[g]   = 1'b0;
      end
    end
    @(negedge clock);
    cmp_cnt++;
    if (wr_en !== exp_en || (exp_en && {wr_data, wr_x, wr_y} !== exp_w)) begin
      err_cnt++;
      $display("FAIL rand_last_write: got en=%b w=%h expected en=%b w=%h",
               wr_en, {wr_data, wr_x, wr_y}, exp_en, exp_w);
    end
    v[0] = 1'b0; v[1] = 1'b0; drive_reqs();
  endtask

  task automatic test_clear_sweep();
    int busy_cnt = 0, wr_cnt = 0, bad_k = -1, ready_bad = 0;
    bit done = 0;
    logic [29:0] first_w = '0, last_w = '0;
    do_reset();
    @(negedge clock);
    set_req(0, 8'h5A, 1, 2);
    set_req(1, 8'hA5, 3, 4);
    drive_reqs();
    clear_req = 1'b1;
    #1;
    cmp_cnt++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      err_cnt++;
      $display("FAIL clear_priority: got %b%b expected 00", req1_ready, req0_ready);
    end
    for (int i = 0; i < 80000 && !done; i++) begin
      @(negedge clock);
      if (wr_en) begin
        if (wr_cnt == 0) first_w = {wr_data, wr_x, wr_y};
        last_w = {wr_data, wr_x, wr_y};
        if (bad_k < 0 && {wr_data, wr_x, wr_y} !==
            {8'hFF, 11'((wr_cnt % H) * 2), 11'((wr_cnt / H) * 2)}) bad_k = wr_cnt;
        wr_cnt++;
      end
      if (clear_busy) busy_cnt++;
      if (!clear_busy && busy_cnt > 0) begin
        done = 1;
      end else begin
        clear_req = (busy_cnt == 1000);
        #1;
        if (clear_busy && (req0_ready || req1_ready)) ready_bad++;
      end
    end
    clear_req = 1'b0;
    #1;
    cmp_cnt++;
    if (!done) begin
      err_cnt++;
      $display("FAIL sweep_timeout: got busy_cnt=%0d expected end of sweep", busy_cnt);
    end
    cmp_cnt++;
    if (busy_cnt !== H * V || wr_cnt !== H * V) begin
      err_cnt++;
      $display("FAIL sweep_length: got busy=%0d writes=%0d expected %0d", busy_cnt, wr_cnt, H * V);
    end
    cmp_cnt++;
    if (first_w !== {8'hFF, 11'd0, 11'd0} || last_w !== {8'hFF, 11'd638, 11'd478}) begin
      err_cnt++;
      $display("FAIL sweep_ends: got first=%h last=%h expected %h %h",
               first_w, last_w, {8'hFF, 11'd0, 11'd0}, {8'hFF, 11'd638, 11'd478});
    end
    cmp_cnt++;
    if (bad_k !== -1) begin
      err_cnt++;
      $display("FAIL sweep_coords: got first bad index %0d expected none", bad_k);
    end
    cmp_cnt++;
    if (ready_bad !== 0) begin
      err_cnt++;
      $display("FAIL sweep_no_ready: got %0d cycles with ready expected 0", ready_bad);
    end
    cmp_cnt++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL ready_resume: got %b%b expected 01", req1_ready, req0_ready);
    end
    @(negedge clock);
    v[0] = 1'b0; v[1] = 1'b0; drive_reqs();
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt = 0;
    do_reset();
    @(negedge clock);
    clear_req = 1'b1;
    for (int i = 0; i < 1000 && busy_cnt < 500; i++) begin
      @(negedge clock);
      clear_req = 1'b0;
      if (clear_busy) busy_cnt++;
    end
    reset = 1'b0;
    @(negedge clock);
    cmp_cnt++;
    if ({wr_en, clear_busy} !== 2'b00 || busy_cnt !== 500) begin
      err_cnt++;
      $display("FAIL abort_sweep: got en=%b busy=%b cnt=%0d expected 0 0 500", wr_en, clear_busy, busy_cnt);
    end
    reset = 1'b1;
    last_g = 1;
`ifdef FB_AUTOCLEAR_EN
    begin
      bit seen_busy = 0, got_wr = 0;
      logic [29:0] w = '0;
      for (int i = 0; i < 6 && !got_wr; i++) begin
        @(negedge clock);
        if (clear_busy) seen_busy = 1;
        if (wr_en) begin got_wr = 1; w = {wr_data, wr_x, wr_y}; end
      end
      cmp_cnt++;
      if (!seen_busy || !got_wr || w !== {8'hFF, 11'd0, 11'd0}) begin
        err_cnt++;
        $display("FAIL autoclear_restart: got busy=%b wr=%b w=%h expected sweep from 0,0", seen_busy, got_wr, w);
      end
    end
`else
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      cmp_cnt++;
      if ({wr_en, clear_busy} !== 2'b00) begin
        err_cnt++;
        $display("FAIL stay_idle c=%0d: got en=%b busy=%b expected 0 0", c, wr_en, clear_busy);
      end
    end
    @(negedge clock);
    set_req(1, 8'h77, 9, 9);
    drive_reqs();
    #1;
    cmp_cnt++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      err_cnt++;
      $display("FAIL idle_after_abort: got %b%b expected 10", req1_ready, req0_ready);
    end
    @(negedge clock);
    v[1] = 1'b0; drive_reqs();
`endif
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; pd[n] = '0; px[n] = '0; py[n] = '0;
    end
    last_g = 1;
    exp_en = 1'b0;
    exp_w  = '0;
    test_reset();
    test_single();
    test_alternate();
    test_random();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_COLOR, default 8'hFF, pixel value written during a clear sweep.
REQ-002 SHALL have parameter H_PIX, default 320, framebuffer columns.
REQ-003 SHALL have parameter V_PIX, default 240, framebuffer rows.
REQ-004 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port clear_req  input  1  single-cycle request to fill the framebuffer with CLEAR_COLOR.
REQ-007 SHALL have port clear_busy  output  1  high while a clear sweep is in progress.
REQ-008 SHALL have ports reqN_valid  input  1, reqN_data  input  8, reqN_x  input  11, reqN_y  input  11, for N = 0,1: requester N pixel write at 640x480-scale coordinates.
REQ-009 SHALL have port reqN_ready  output  1  for N = 0,1: requester N write accepted this cycle.
REQ-010 SHALL have ports wr_en  output  1, wr_data  output  8, wr_x  output  11, wr_y  output  11: write port to the framebuffer, 640x480-scale coordinates.

Function
REQ-011 SHALL implement FSM states IDLE and CLEAR.
REQ-012 In IDLE, reqN_ready SHALL be combinational: asserted for at most one N per cycle, only when reqN_valid=1 and clear_req=0.
REQ-013 Transfer occurs on valid&ready; wr_en/wr_data/wr_x/wr_y SHALL be registered, presenting the accepted write exactly 1 cycle after transfer, wr_en=1 for exactly that cycle.
REQ-014 When both valid, grant SHALL go to the requester not granted most recently (round-robin pointer); pointer updates only on a transfer; reset pointer favours requester 0.
REQ-015 With one valid requester, it SHALL be granted every cycle (back-to-back, full throughput).
REQ-016 clear_req=1 in IDLE SHALL take priority over requesters that cycle (no ready) and enter CLEAR next cycle.
REQ-017 In CLEAR, both reqN_ready SHALL be 0 and clear_busy SHALL be 1.
REQ-018 In CLEAR, a column counter (0..H_PIX-1) and row counter (0..V_PIX-1) SHALL emit one write per cycle: wr_en=1, wr_data=CLEAR_COLOR, wr_x=col*2, wr_y=row*2, column fastest.
REQ-019 Column wrap H_PIX-1 -> 0 SHALL increment row; on last pixel (H_PIX-1, V_PIX-1) FSM SHALL return to IDLE, counters to 0; a sweep is exactly H_PIX*V_PIX wr_en cycles.
REQ-020 clear_req during CLEAR SHALL be ignored (no restart, no queuing).
REQ-021 Requester inputs SHALL not be modified/latched while not ready; requesters hold valid and payload until ready.

Reset
REQ-022 While reset=0 at a clock edge: wr_en=0, wr_data=0, wr_x=0, wr_y=0, clear_busy=0, counters=0, RR pointer=requester 0.
REQ-023 Reset mid-sweep SHALL abort the sweep immediately; post-reset state per REQ-024.
REQ-024 Post-reset state SHALL be IDLE unless REQ-025 applies.

Configuration
REQ-025 With FB_AUTOCLEAR_EN defined, first cycle after reset release SHALL enter CLEAR (full sweep without clear_req); without it, FSM SHALL start in IDLE and clear only on clear_req.

Structure
REQ-026 Shared package SHALL hold FSM state typedef, CLEAR_COLOR default, H_PIX/V_PIX defaults, coordinate width (11).
REQ-027 Sub-module clear_sweep_counter (column/row counters, last-pixel flag) SHALL be used; arbitration and FSM remain in top.

Verification
REQ-028 Only req0 valid, x=100,y=50,data=8'h3C held 3 cycles -> ready0=1 each cycle; wr_en=1 with wr_x=100,wr_y=50,wr_data=8'h3C cycles 1..3 after.
REQ-029 Both valid continuously 4 cycles after reset -> grants 0,1,0,1; wr_data alternates req0/req1 payloads.
REQ-030 clear_req pulse with both valid -> no ready that cycle; clear_busy=1 for 76800 cycles; first write (0,0,8'hFF), last (638,478,8'hFF); ready resumes after.
REQ-031 clear_req re-pulsed at sweep cycle 1000 -> sweep length still 76800, no restart.
REQ-032 reset=0 at sweep cycle 500 -> next cycle wr_en=0, clear_busy=0; FB_AUTOCLEAR_EN build restarts full sweep from (0,0) after release, default build stays IDLE.
